// File: rtl/des_stream_ctrl.sv
// Host-side stream controller for a pipelined DES core: credit-gated issue of
// ready/valid blocks to the core and collection of results into an output FIFO.
module des_stream_ctrl #(
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    input  logic [63:0]      s_key,
    input  logic             s_decrypt,
    output logic [63:0]      core_plain_text,
    output logic [63:0]      core_cipher_key,
    output logic             core_enc_dec,
    output logic             core_valid_in,
    input  logic             core_valid_out,
    input  logic [63:0]      core_cipher_text,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [CNT_W-1:0] fifo_count,
    output logic             err_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [CNT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [63:0]      plain_q, plain_d;
    logic [63:0]      key_q, key_d;
    logic             enc_dec_q, enc_dec_d;
    logic             valid_in_q, valid_in_d;
    logic             err_q, err_d;
    logic [63:0]      mem [FIFO_DEPTH];

    logic accept, pop, full, push_ok;

    assign s_ready = (credit_q != '0);
    assign m_valid = (count_q != '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign accept  = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign push_ok = core_valid_out & (~full | pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        credit_d   = credit_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        plain_d    = plain_q;
        key_d      = key_q;
        enc_dec_d  = enc_dec_q;
        valid_in_d = 1'b0;
        err_d      = err_q;

        // Credit saturates at FIFO_DEPTH so stray core results cannot mint credit.
        if (accept && !pop) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (pop && !accept && credit_q != CNT_W'(FIFO_DEPTH)) begin
            credit_d = credit_q + CNT_W'(1);
        end

        if (accept) begin
            plain_d    = s_data;
            key_d      = s_key;
            enc_dec_d  = s_decrypt;
            valid_in_d = 1'b1;
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        if (core_valid_out && full && !pop) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rstn) begin
            credit_q   <= CNT_W'(FIFO_DEPTH);
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            plain_q    <= '0;
            key_q      <= '0;
            enc_dec_q  <= 1'b0;
            valid_in_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            plain_q    <= plain_d;
            key_q      <= key_d;
            enc_dec_q  <= enc_dec_d;
            valid_in_q <= valid_in_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count_q, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= core_cipher_text;
    end

    assign m_data          = mem[rd_ptr_q];
    assign fifo_count      = count_q;
    assign err_overflow    = err_q;
    assign core_plain_text = plain_q;
    assign core_cipher_key = key_q;
    assign core_enc_dec    = enc_dec_q;
    assign core_valid_in   = valid_in_q;

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Scoreboard bench for des_stream_ctrl with a fixed-latency DES core stub that
// knows the standard DES test pair and an injection port for spurious results.
module tb_des_stream_ctrl;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int LAT   = 4;
    localparam logic [63:0] K = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] P = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C = 64'h85E8_1354_0F0A_B405;

    logic             clk, rstn;
    logic             s_valid, s_ready, s_decrypt;
    logic [63:0]      s_data, s_key;
    logic [63:0]      core_plain_text, core_cipher_key, core_cipher_text;
    logic             core_enc_dec, core_valid_in, core_valid_out;
    logic             m_valid, m_ready;
    logic [63:0]      m_data;
    logic [CNT_W-1:0] fifo_count;
    logic             err_overflow;

    logic             inj_v;
    logic [63:0]      inj_d;

    int          n_cmp, n_err;
    logic [63:0] exp_q[$];
    int          idx, lim;

    des_stream_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key), .s_decrypt(s_decrypt),
        .core_plain_text(core_plain_text), .core_cipher_key(core_cipher_key),
        .core_enc_dec(core_enc_dec), .core_valid_in(core_valid_in),
        .core_valid_out(core_valid_out), .core_cipher_text(core_cipher_text),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .fifo_count(fifo_count), .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: the DES pair is answered exactly, anything else gets a cheap keyed scramble.
    function automatic logic [63:0] core_f(logic [63:0] t, logic [63:0] k, logic d);
        if (k == K && t == P && !d) return C;
        if (k == K && t == C &&  d) return P;
        return {t[31:0], t[63:32]} ^ k ^ {64{d}};
    endfunction

    logic [LAT-1:0] pv;
    logic [63:0]    pd [LAT];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) pv <= '0;
        else       pv <= {pv[LAT-2:0], core_valid_in};
    end

    always @(posedge clk) begin
        pd[0] <= core_f(core_plain_text, core_cipher_key, core_enc_dec);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end

    assign core_valid_out   = pv[LAT-1] | inj_v;
    assign core_cipher_text = inj_v ? inj_d : pd[LAT-1];

    // Block i with key K, encrypt: swapped halves of i xor K, i.e. (i << 32) ^ K.
    function automatic logic [63:0] blk_exp(int i);
        return (64'(i) << 32) ^ K;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every downstream handshake pops one expected result.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", m_data);
            end else begin
                check("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stream_cycle();
        logic acc;
        @(negedge clk);
        acc = s_valid && s_ready;
        if (acc) exp_q.push_back(blk_exp(idx));
        @(posedge clk);
        #1;
        if (acc) begin
            idx++;
            if (idx >= lim) s_valid = 1'b0;
            else            s_data  = 64'(idx);
        end
    endtask

    task automatic issue(int n);
        lim       = idx + n;
        s_data    = 64'(idx);
        s_key     = K;
        s_decrypt = 1'b0;
        s_valid   = 1'b1;
        for (int c = 0; c < 50 && idx < lim; c++) stream_cycle();
        s_valid = 1'b0;
        check("issue_done", 64'(idx), 64'(lim));
    endtask

    task automatic send_one(logic [63:0] d, logic [63:0] k, logic dec, logic [63:0] e);
        logic ok;
        ok        = 1'b0;
        s_data    = d;
        s_key     = k;
        s_decrypt = dec;
        s_valid   = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
        end
        check("send_accepted", 64'(ok), 64'd1);
        if (ok) exp_q.push_back(e);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("issue_valid_in", 64'(core_valid_in), 64'd1);
        check("issue_plain", core_plain_text, d);
        check("issue_key", core_cipher_key, k);
        check("issue_enc_dec", 64'(core_enc_dec), 64'(dec));
    endtask

    initial begin
        logic found;
        n_cmp = 0; n_err = 0; idx = 0; lim = 0;
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_key = '0; s_decrypt = 1'b0;
        m_ready = 1'b1; inj_v = 1'b0; inj_d = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_valid_in", 64'(core_valid_in), 64'd0);
        check("rst_plain", core_plain_text, 64'd0);
        check("rst_key", core_cipher_key, 64'd0);
        check("rst_enc_dec", 64'(core_enc_dec), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_err", 64'(err_overflow), 64'd0);
        rstn = 1'b1;
        wait_cycles(2);
        check("rel_s_ready", 64'(s_ready), 64'd1);

        // 1: encrypt the DES pair; one valid_in pulse, m_valid one cycle after valid_out
        send_one(P, K, 1'b0, C);
        wait_cycles(1);
        check("t1_pulse_one_cycle", 64'(core_valid_in), 64'd0);
        check("t1_key_held", core_cipher_key, K);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (core_valid_out) found = 1'b1;
        end
        check("t1_valid_out_seen", 64'(found), 64'd1);
        check("t1_no_bypass", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("t1_m_valid_next", 64'(m_valid), 64'd1);
        wait_cycles(3);
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // 2: decrypt back to the plaintext
        send_one(C, K, 1'b1, P);
        wait_cycles(10);
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // 3: stall downstream, hold s_valid for 12 blocks
        m_ready = 1'b0; idx = 0; lim = 12;
        s_key = K; s_decrypt = 1'b0; s_data = '0; s_valid = 1'b1;
        repeat (20) stream_cycle();
        check("t3_accepted", 64'(idx), 64'd8);
        check("t3_s_ready", 64'(s_ready), 64'd0);
        check("t3_count", 64'(fifo_count), 64'd8);
        check("t3_err", 64'(err_overflow), 64'd0);
        check("t3_head_held", m_data, blk_exp(0));

        // 4: release downstream; credit returns after the first pop
        m_ready = 1'b1;
        stream_cycle();
        check("t4_s_ready_after_pop", 64'(s_ready), 64'd1);
        repeat (40) stream_cycle();
        check("t4_all_issued", 64'(idx), 64'd12);
        check("t4_count", 64'(fifo_count), 64'd0);
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // 5: credit=1 with accept and pop together, then full-boundary pushes
        m_ready = 1'b0;
        issue(7);
        wait_cycles(8);
        check("t5_count7", 64'(fifo_count), 64'd7);
        check("t5_credit1", 64'(s_ready), 64'd1);
        lim = idx + 1; s_data = 64'(idx); s_valid = 1'b1; m_ready = 1'b1;
        stream_cycle();
        m_ready = 1'b0;
        check("t5_accept_with_pop", 64'(idx), 64'd20);
        check("t5_s_ready_kept", 64'(s_ready), 64'd1);
        wait_cycles(8);
        check("t5_count7b", 64'(fifo_count), 64'd7);
        issue(1);
        wait_cycles(8);
        check("t5_full", 64'(fifo_count), 64'd8);
        check("t5_no_credit", 64'(s_ready), 64'd0);
        inj_d = 64'hA5A5_A5A5_5A5A_5A5A; inj_v = 1'b1; m_ready = 1'b1;
        exp_q.push_back(inj_d);
        wait_cycles(1);
        inj_v = 1'b0; m_ready = 1'b0;
        check("t5_full_push_pop_count", 64'(fifo_count), 64'd8);
        check("t5_full_push_pop_err", 64'(err_overflow), 64'd0);
        inj_d = 64'hDEAD_BEEF_CAFE_F00D; inj_v = 1'b1;
        wait_cycles(1);
        inj_v = 1'b0;
        check("t5_overflow_err", 64'(err_overflow), 64'd1);
        check("t5_overflow_count", 64'(fifo_count), 64'd8);
        check("t5_overflow_head", m_data, blk_exp(14));
        wait_cycles(3);
        check("t5_err_sticky", 64'(err_overflow), 64'd1);
        m_ready = 1'b1;
        wait_cycles(15);
        check("t5_count0", 64'(fifo_count), 64'd0);
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        check("t5_err_still", 64'(err_overflow), 64'd1);
        check("t5_credit_full", 64'(s_ready), 64'd1);

        // 6: reset with 3 blocks in flight and 2 in the FIFO
        m_ready = 1'b0;
        issue(2);
        wait_cycles(8);
        check("t6_count2", 64'(fifo_count), 64'd2);
        issue(3);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_count", 64'(fifo_count), 64'd0);
        check("t6_rst_m_valid", 64'(m_valid), 64'd0);
        check("t6_rst_s_ready", 64'(s_ready), 64'd1);
        check("t6_rst_err", 64'(err_overflow), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_ready = 1'b1;
        wait_cycles(12);
        check("t6_no_stale_count", 64'(fifo_count), 64'd0);
        check("t6_no_stale_valid", 64'(m_valid), 64'd0);
        issue(1);
        wait_cycles(10);
        check("t6_new_block_out", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
